// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns a MEM-stage load/store into a single RAM word access with lane steering and load extension.
// Latency: 3 cycles minimum per access (IDLE, ACCESS with same-cycle ack, DONE); a missing ack times out after MAX_WAIT ACCESS cycles.
// Backpressure: stall_o holds IF..MEM while an access is in flight; ram_req_o and its qualifiers stay stable until ram_ack_i.
module dmem_ctrl #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [2:0]  mem_funct3_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] rd_data_mem_i,
    input  logic [31:0] wb_data_i,
    input  logic        forwardC_mem_i,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        fault_o,
    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_be_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic        ram_ack_i,
    input  logic [31:0] ram_rdata_i
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t         state;
    logic [31:0]    addr_q;
    logic [2:0]     funct3_q;
    logic           we_q;
    logic [CW-1:0]  wait_cnt;

    logic           f3_ok;
    logic           aligned;
    logic           legal;
    logic [31:0]    store_data;
    logic [3:0]     st_be;
    logic [31:0]    st_wdata;
    logic [7:0]     ld_byte;
    logic [15:0]    ld_half;
    logic [31:0]    ld_ext;

    // Stores only have B/H/W encodings; the unsigned codes are load-only.
    always_comb begin
        f3_ok = 1'b0;
        case (mem_funct3_i)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = ~mem_we_i;
            default:                f3_ok = 1'b0;
        endcase
    end

    always_comb begin
        aligned = 1'b1;
        case (mem_funct3_i[1:0])
            2'b01:   aligned = ~mem_addr_i[0];
            2'b10:   aligned = (mem_addr_i[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    assign legal      = mem_req_i & f3_ok & aligned;
    assign store_data = forwardC_mem_i ? wb_data_i : rd_data_mem_i;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = store_data;
        case (mem_funct3_i[1:0])
            2'b00: begin
                st_be    = 4'b0001 << mem_addr_i[1:0];
                st_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << {mem_addr_i[1], 1'b0};
                st_wdata = {2{store_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = store_data;
            end
        endcase
    end

    // Lane select uses the address latched at acceptance, not the live pipeline input.
    always_comb begin
        ld_byte = ram_rdata_i[7:0];
        case (addr_q[1:0])
            2'b00:   ld_byte = ram_rdata_i[7:0];
            2'b01:   ld_byte = ram_rdata_i[15:8];
            2'b10:   ld_byte = ram_rdata_i[23:16];
            default: ld_byte = ram_rdata_i[31:24];
        endcase
        ld_half = addr_q[1] ? ram_rdata_i[31:16] : ram_rdata_i[15:0];
        ld_ext  = ram_rdata_i;
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = ram_rdata_i;
        endcase
    end

    assign stall_o = (state == ACCESS) || ((state == IDLE) && !rst && legal);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            addr_q       <= '0;
            funct3_q     <= '0;
            we_q         <= 1'b0;
            wait_cnt     <= '0;
            load_data_o  <= '0;
            load_valid_o <= 1'b0;
            fault_o      <= 1'b0;
            ram_req_o    <= 1'b0;
            ram_we_o     <= 1'b0;
            ram_be_o     <= '0;
            ram_addr_o   <= '0;
            ram_wdata_o  <= '0;
        end else begin
            load_valid_o <= 1'b0;
            fault_o      <= 1'b0;
            case (state)
                IDLE: begin
                    if (legal) begin
                        state       <= ACCESS;
                        addr_q      <= mem_addr_i;
                        funct3_q    <= mem_funct3_i;
                        we_q        <= mem_we_i;
                        wait_cnt    <= '0;
                        ram_req_o   <= 1'b1;
                        ram_we_o    <= mem_we_i;
                        ram_be_o    <= mem_we_i ? st_be : 4'b1111;
                        ram_addr_o  <= {mem_addr_i[31:2], 2'b00};
                        ram_wdata_o <= mem_we_i ? st_wdata : 32'd0;
                    end else if (mem_req_i) begin
                        fault_o <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (ram_ack_i || (wait_cnt == CW'(MAX_WAIT - 1))) begin
                        state       <= DONE;
                        ram_req_o   <= 1'b0;
                        ram_we_o    <= 1'b0;
                        ram_be_o    <= '0;
                        ram_addr_o  <= '0;
                        ram_wdata_o <= '0;
                        fault_o     <= ~ram_ack_i;
                        if (!we_q) begin
                            load_data_o  <= ram_ack_i ? ld_ext : 32'd0;
                            load_valid_o <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: loads with lane extension, stores with forwarding, faults, timeout and reset mid-access.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_i, mem_we_i, forwardC_mem_i, ram_ack_i;
    logic [2:0]  mem_funct3_i;
    logic [31:0] mem_addr_i, rd_data_mem_i, wb_data_i, ram_rdata_i;
    logic        stall_o, load_valid_o, fault_o, ram_req_o, ram_we_o;
    logic [31:0] load_data_o, ram_addr_o, ram_wdata_o;
    logic [3:0]  ram_be_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.MAX_WAIT(16)) dut (
        .clk(clk), .rst(rst),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_funct3_i(mem_funct3_i),
        .mem_addr_i(mem_addr_i), .rd_data_mem_i(rd_data_mem_i), .wb_data_i(wb_data_i),
        .forwardC_mem_i(forwardC_mem_i),
        .stall_o(stall_o), .load_data_o(load_data_o), .load_valid_o(load_valid_o),
        .fault_o(fault_o), .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
        .ram_ack_i(ram_ack_i), .ram_rdata_i(ram_rdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns in the first cycle after acceptance edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic fwd, input logic [31:0] rs2, input logic [31:0] wb);
        mem_req_i      = 1'b1;
        mem_we_i       = we;
        mem_funct3_i   = f3;
        mem_addr_i     = addr;
        forwardC_mem_i = fwd;
        rd_data_mem_i  = rs2;
        wb_data_i      = wb;
        #1;
        chk("stall_in_idle", {31'd0, stall_o}, 32'd1);
        tick();
        mem_req_i     = 1'b0;
        rd_data_mem_i = 32'd0;
        wb_data_i     = 32'd0;
    endtask

    // Ack in the first ACCESS cycle, then check the DONE-cycle load result.
    task automatic load_ack(input string tag, input logic [31:0] rdata, input logic [31:0] exp);
        ram_ack_i   = 1'b1;
        ram_rdata_i = rdata;
        tick();
        ram_ack_i = 1'b0;
        chk({tag, "_data"},  load_data_o, exp);
        chk({tag, "_valid"}, {31'd0, load_valid_o}, 32'd1);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_funct3_i = 3'b000; mem_addr_i = '0;
        rd_data_mem_i = '0; wb_data_i = '0; forwardC_mem_i = 1'b0;
        ram_ack_i = 1'b0; ram_rdata_i = '0;
        tick();
        tick();
        chk("rst_req",   {31'd0, ram_req_o}, 32'd0);
        chk("rst_valid", {31'd0, load_valid_o}, 32'd0);
        chk("rst_fault", {31'd0, fault_o}, 32'd0);
        chk("rst_data",  load_data_o, 32'd0);
        mem_req_i = 1'b1; mem_funct3_i = 3'b010; mem_addr_i = 32'h100;
        #1;
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        mem_req_i = 1'b0;
        rst = 1'b0;
        tick();

        // LW 0x100, ack on second ACCESS cycle
        issue(1'b0, 3'b010, 32'h100, 1'b0, 32'h0, 32'h0);
        chk("lw_req",   {31'd0, ram_req_o}, 32'd1);
        chk("lw_addr",  ram_addr_o, 32'h100);
        chk("lw_be",    {28'd0, ram_be_o}, 32'hF);
        chk("lw_we",    {31'd0, ram_we_o}, 32'd0);
        chk("lw_stall1", {31'd0, stall_o}, 32'd1);
        tick();
        ram_ack_i = 1'b1; ram_rdata_i = 32'hDEADBEEF;
        #1;
        chk("lw_stall2", {31'd0, stall_o}, 32'd1);
        chk("lw_req2",  {31'd0, ram_req_o}, 32'd1);
        tick();
        ram_ack_i = 1'b0;
        chk("lw_data",  load_data_o, 32'hDEADBEEF);
        chk("lw_valid", {31'd0, load_valid_o}, 32'd1);
        chk("lw_done_stall", {31'd0, stall_o}, 32'd0);
        chk("lw_done_req", {31'd0, ram_req_o}, 32'd0);
        tick();
        chk("lw_valid_end", {31'd0, load_valid_o}, 32'd0);
        chk("lw_hold", load_data_o, 32'hDEADBEEF);

        // Lane extraction
        issue(1'b0, 3'b000, 32'h103, 1'b0, 32'h0, 32'h0);
        load_ack("lb", 32'h80FF_0000, 32'hFFFFFF80);
        issue(1'b0, 3'b100, 32'h103, 1'b0, 32'h0, 32'h0);
        load_ack("lbu", 32'h80FF_0000, 32'h00000080);
        issue(1'b0, 3'b101, 32'h102, 1'b0, 32'h0, 32'h0);
        load_ack("lhu", 32'h80FF_0000, 32'h000080FF);
        issue(1'b0, 3'b001, 32'h100, 1'b0, 32'h0, 32'h0);
        load_ack("lh", 32'h1234_8001, 32'hFFFF8001);

        // SB with forwarding; source data changes after acceptance
        issue(1'b1, 3'b000, 32'h201, 1'b1, 32'hAAAAAAAA, 32'h12345678);
        chk("sb_be",    {28'd0, ram_be_o}, 32'h2);
        chk("sb_wdata", ram_wdata_o, 32'h78787878);
        chk("sb_we",    {31'd0, ram_we_o}, 32'd1);
        chk("sb_addr",  ram_addr_o, 32'h200);
        ram_ack_i = 1'b1;
        tick();
        ram_ack_i = 1'b0;
        chk("sb_no_valid", {31'd0, load_valid_o}, 32'd0);
        chk("sb_no_fault", {31'd0, fault_o}, 32'd0);
        chk("sb_data_hold", load_data_o, 32'hFFFF8001);
        tick();

        issue(1'b1, 3'b001, 32'h202, 1'b0, 32'hAAAA5555, 32'h0);
        chk("sh_be",    {28'd0, ram_be_o}, 32'hC);
        chk("sh_wdata", ram_wdata_o, 32'h55555555);
        ram_ack_i = 1'b1; tick(); ram_ack_i = 1'b0; tick();
        issue(1'b1, 3'b010, 32'h204, 1'b0, 32'hCAFEF00D, 32'h0);
        chk("sw_be",    {28'd0, ram_be_o}, 32'hF);
        chk("sw_wdata", ram_wdata_o, 32'hCAFEF00D);
        ram_ack_i = 1'b1; tick(); ram_ack_i = 1'b0; tick();

        // Misaligned LW
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_funct3_i = 3'b010; mem_addr_i = 32'h102;
        #1;
        chk("mis_stall", {31'd0, stall_o}, 32'd0);
        tick();
        mem_req_i = 1'b0;
        chk("mis_fault", {31'd0, fault_o}, 32'd1);
        chk("mis_req",   {31'd0, ram_req_o}, 32'd0);
        tick();
        chk("mis_fault_end", {31'd0, fault_o}, 32'd0);

        // Store with a load-only width code
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_funct3_i = 3'b100; mem_addr_i = 32'h300;
        #1;
        chk("ilf3_stall", {31'd0, stall_o}, 32'd0);
        tick();
        mem_req_i = 1'b0;
        chk("ilf3_fault", {31'd0, fault_o}, 32'd1);
        chk("ilf3_req",   {31'd0, ram_req_o}, 32'd0);
        tick();

        // Timeout: 16 ACCESS cycles without ack
        issue(1'b0, 3'b010, 32'h300, 1'b0, 32'h0, 32'h0);
        for (int i = 2; i <= 16; i++) begin
            tick();
            chk("to_req_held", {31'd0, ram_req_o}, 32'd1);
        end
        tick();
        chk("to_fault", {31'd0, fault_o}, 32'd1);
        chk("to_valid", {31'd0, load_valid_o}, 32'd1);
        chk("to_data",  load_data_o, 32'd0);
        chk("to_req",   {31'd0, ram_req_o}, 32'd0);
        tick();
        chk("to_fault_end", {31'd0, fault_o}, 32'd0);
        chk("to_idle_stall", {31'd0, stall_o}, 32'd0);

        // Put a nonzero value in load_data_o, then reset in the second ACCESS cycle
        issue(1'b0, 3'b010, 32'h100, 1'b0, 32'h0, 32'h0);
        load_ack("pre_rst", 32'h5A5A5A5A, 32'h5A5A5A5A);
        issue(1'b0, 3'b010, 32'h400, 1'b0, 32'h0, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_acc_req",   {31'd0, ram_req_o}, 32'd0);
        chk("rst_acc_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_acc_data",  load_data_o, 32'd0);
        ram_ack_i = 1'b1; ram_rdata_i = 32'h11111111;
        tick();
        ram_ack_i = 1'b0;
        chk("rst_ack_valid", {31'd0, load_valid_o}, 32'd0);
        chk("rst_ack_fault", {31'd0, fault_o}, 32'd0);
        chk("rst_ack_data",  load_data_o, 32'd0);
        chk("rst_ack_req",   {31'd0, ram_req_o}, 32'd0);
        tick();
        chk("rst_ack_valid2", {31'd0, load_valid_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
